hawk_seq_param: RTL and testbench

HAWK_SEQ_PARAM -- requirements
Module: hawk_seq_param

---
 rtl/hawk_seq_param.sv | 181 ++++++++++++++++++
 tb/tb_hawk_seq_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_seq_param.sv
// Pedestrian-crossing lamp sequencer (HAWK beacon) with tick prescaler, blink and preemption.
// Outputs are combinational from the registered state; transitions take one clock; no backpressure.
module hawk_seq_param #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8,
  parameter int N_PB     = 2,
  parameter int T_FY     = 3,
  parameter int T_SY     = 4,
  parameter int T_WALK   = 7,
  parameter int T_FDW    = 10,
  parameter int T_GAP    = 20,
  parameter int BLINK    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_PB-1:0]  pb,
  input  logic             preempt,
  output logic             YL,
  output logic             RL_L,
  output logic             RL_R,
  output logic             W,
  output logic             DNW,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       present_state,
  output logic [2:0]       next_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;

  typedef enum logic [2:0] {
    S_DARK     = 3'd0,
    S_FLASH_Y  = 3'd1,
    S_STEADY_Y = 3'd2,
    S_RED_WALK = 3'd3,
    S_FDW      = 3'd4,
    S_GAP      = 3'd5
  } state_e;

  // Held as a plain vector so the unused codes 6-7 remain representable.
  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  logic             req_q, req_d;

  logic             tick;
  logic             expired;
  logic             changing;
  logic [CNT_W-1:0] phase_len;

  always_comb begin
    phase_len = '0;
    case (state_q)
      S_FLASH_Y:  phase_len = CNT_W'(T_FY);
      S_STEADY_Y: phase_len = CNT_W'(T_SY);
      S_RED_WALK: phase_len = CNT_W'(T_WALK);
      S_FDW:      phase_len = CNT_W'(T_FDW);
      S_GAP:      phase_len = CNT_W'(T_GAP);
      default:    phase_len = '0;
    endcase
  end

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign expired = tick && (timer_q == phase_len - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DARK: begin
        if (req_q && !preempt) state_d = S_FLASH_Y;
      end
      S_FLASH_Y: begin
        if (preempt)      state_d = S_DARK;
        else if (expired) state_d = S_STEADY_Y;
      end
      S_STEADY_Y: begin
        if (preempt)      state_d = S_DARK;
        else if (expired) state_d = S_RED_WALK;
      end
      // Preemption may shorten WALK but never the flashing clearance after it.
      S_RED_WALK: begin
        if (preempt || expired) state_d = S_FDW;
      end
      S_FDW: begin
        if (expired) state_d = S_GAP;
      end
      S_GAP: begin
        if (expired) state_d = S_DARK;
      end
      default: state_d = S_DARK;
    endcase
  end

  assign changing = (state_d != state_q);

  always_comb begin
    presc_d = presc_q + PW'(1);
    timer_d = timer_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (changing) begin
      presc_d = '0;
      timer_d = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (tick) begin
      presc_d = '0;
      timer_d = timer_q + CNT_W'(1);
      if (bcnt_q == BW'(BLINK - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    req_d = req_q;
    if ((|pb) && (state_q == S_DARK || state_q == S_GAP)) req_d = 1'b1;
    if (preempt && (state_q == S_FLASH_Y || state_q == S_STEADY_Y)) req_d = 1'b1;
    // Entering the flashing phase consumes the request, even against a same-cycle set.
    if (state_d == S_FLASH_Y && state_q != S_FLASH_Y) req_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_DARK;
      presc_q <= '0;
      timer_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    YL        = 1'b0;
    RL_L      = 1'b0;
    RL_R      = 1'b0;
    W         = 1'b0;
    DNW       = 1'b1;
    countdown = '0;
    case (state_q)
      S_FLASH_Y:  YL = blink_q;
      S_STEADY_Y: YL = 1'b1;
      S_RED_WALK: begin
        RL_L      = 1'b1;
        RL_R      = 1'b1;
        W         = 1'b1;
        DNW       = 1'b0;
        countdown = phase_len - timer_q;
      end
      S_FDW: begin
        RL_L      = blink_q;
        RL_R      = ~blink_q;
        DNW       = blink_q;
        countdown = phase_len - timer_q;
      end
      default: ;
    endcase
  end

  assign req_pending   = req_q;
  assign present_state = state_q;
  assign next_state    = state_d;

  a_walk_excl: assert property (@(posedge clk) !(W && DNW));
  a_walk_only: assert property (@(posedge clk) W |-> (state_q == S_RED_WALK));

endmodule

// File: tb/tb_hawk_seq_param.sv
// Scoreboarded bench: driver pushes reference-model expectations, monitor pops and compares each cycle.
module tb_hawk_seq_param;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int N_PB     = 2;
  localparam int T_FY     = 3;
  localparam int T_SY     = 4;
  localparam int T_WALK   = 7;
  localparam int T_FDW    = 10;
  localparam int T_GAP    = 20;
  localparam int BLINK    = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N_PB-1:0]  pb = '0;
  logic             preempt = 1'b0;
  logic             YL, RL_L, RL_R, W, DNW, req_pending;
  logic [CNT_W-1:0] countdown;
  logic [2:0]       present_state, next_state;

  always #5 clk = ~clk;

  hawk_seq_param #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .N_PB(N_PB), .T_FY(T_FY), .T_SY(T_SY),
    .T_WALK(T_WALK), .T_FDW(T_FDW), .T_GAP(T_GAP), .BLINK(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .pb(pb), .preempt(preempt),
    .YL(YL), .RL_L(RL_L), .RL_R(RL_R), .W(W), .DNW(DNW),
    .req_pending(req_pending), .countdown(countdown),
    .present_state(present_state), .next_state(next_state)
  );

  typedef struct {
    int st;
    bit yl, rll, rlr, w, dnw, req;
    int cd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: state, cycles spent in that state, latched request.
  int m_st = 0;
  int m_age = 0;
  bit m_req = 0;

  function automatic int ticks_of(int s);
    case (s)
      1: return T_FY;
      2: return T_SY;
      3: return T_WALK;
      4: return T_FDW;
      5: return T_GAP;
      default: return 0;
    endcase
  endfunction

  function automatic int model_next(int s, int age, bit req, bit pre);
    bit done;
    done = (ticks_of(s) > 0) && (age == ticks_of(s) * TICK_DIV - 1);
    case (s)
      0: return (req && !pre) ? 1 : 0;
      1: return pre ? 0 : (done ? 2 : 1);
      2: return pre ? 0 : (done ? 3 : 2);
      3: return (pre || done) ? 4 : 3;
      4: return done ? 5 : 4;
      5: return done ? 0 : 5;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t expect_of(int s, int age, bit req);
    exp_t e;
    bit   bl;
    bl    = (((age / TICK_DIV) / BLINK) % 2) == 0;
    e.st  = s; e.yl = 0; e.rll = 0; e.rlr = 0; e.w = 0; e.dnw = 1; e.req = req; e.cd = 0;
    case (s)
      1: e.yl = bl;
      2: e.yl = 1;
      3: begin e.rll = 1; e.rlr = 1; e.w = 1; e.dnw = 0; e.cd = T_WALK - age / TICK_DIV; end
      4: begin e.rll = bl; e.rlr = !bl; e.dnw = bl; e.cd = T_FDW - age / TICK_DIV; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic [N_PB-1:0] p, input bit pe, input bit rn, input bit illegal);
    int ns;
    bit nreq;
    @(negedge clk);
    pb = p; preempt = pe; reset = rn;
    if (illegal) begin
      force dut.state_q = 3'd6;
      m_st = 6;
    end
    #1;
    if (!rn) begin
      ns = 0; nreq = 0; m_age = 0;
    end else begin
      ns   = model_next(m_st, m_age, m_req, pe);
      nreq = m_req | ((|p) && (m_st == 0 || m_st == 5)) | (pe && (m_st == 1 || m_st == 2));
      if (ns == 1 && m_st != 1) nreq = 0;
      total++;
      if (next_state !== 3'(ns)) begin
        bad++;
        $display("FAIL next_state t=%0t got=%0d exp=%0d", $time, next_state, ns);
      end
      m_age = (ns != m_st) ? 0 : m_age + 1;
    end
    if (illegal) release dut.state_q;
    m_st = ns; m_req = nreq;
    q.push_back(expect_of(m_st, m_age, m_req));
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_const(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: compare every registered cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (present_state !== 3'(e.st) || YL !== e.yl || RL_L !== e.rll || RL_R !== e.rlr ||
            W !== e.w || DNW !== e.dnw || req_pending !== e.req || countdown !== CNT_W'(e.cd)) begin
          bad++;
          $display("FAIL outputs t=%0t got st=%0d yl=%b rl=%b%b w=%b dnw=%b req=%b cd=%0d exp st=%0d yl=%b rl=%b%b w=%b dnw=%b req=%b cd=%0d",
                   $time, present_state, YL, RL_L, RL_R, W, DNW, req_pending, countdown,
                   e.st, e.yl, e.rll, e.rlr, e.w, e.dnw, e.req, e.cd);
        end
      end
    end
  end

  // Phase-length tracker, independent of the model.
  int         last_len[8];
  int         cd_entry[8];
  int         run_len = 0;
  logic [2:0] prev_st = 3'd0;
  initial begin
    for (int i = 0; i < 8; i++) begin last_len[i] = 0; cd_entry[i] = 0; end
    forever begin
      @(posedge clk);
      #1;
      if (present_state == prev_st) begin
        run_len++;
      end else begin
        last_len[prev_st]       = run_len;
        cd_entry[present_state] = int'(countdown);
        run_len                 = 1;
        prev_st                 = present_state;
      end
    end
  end

  initial begin
    logic [N_PB-1:0] rp;
    bit              rpe;
    bit              rrn;
    // Reset, then a full crossing cycle from a single press.
    repeat (3) step('0, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(2'b10, 1'b0, 1'b1, 1'b0);
    idle(185);
    check_const("flash_len", last_len[1], 12);
    check_const("steady_len", last_len[2], 16);
    check_const("walk_len", last_len[3], 28);
    check_const("fdw_len", last_len[4], 40);
    check_const("gap_len", last_len[5], 80);
    check_const("walk_cd_entry", cd_entry[3], 7);
    check_const("fdw_cd_entry", cd_entry[4], 10);

    // Re-request during GAP.
    step(2'b01, 1'b0, 1'b1, 1'b0);
    idle(130);
    step(2'b01, 1'b0, 1'b1, 1'b0);
    idle(260);

    // Preempt in STEADY_Y, held a few cycles, then released.
    step(2'b01, 1'b0, 1'b1, 1'b0);
    idle(15);
    repeat (5) step('0, 1'b1, 1'b1, 1'b0);
    idle(200);

    // Preempt in RED_WALK.
    step(2'b10, 1'b0, 1'b1, 1'b0);
    idle(35);
    step('0, 1'b1, 1'b1, 1'b0);
    idle(200);

    // Mid-phase reset in RED_WALK, with a press on the reset cycle.
    step(2'b10, 1'b0, 1'b1, 1'b0);
    idle(35);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Button held through the sequence.
    step(2'b01, 1'b0, 1'b1, 1'b0);
    repeat (150) step(2'b01, 1'b0, 1'b1, 1'b0);
    idle(260);

    // Illegal state code.
    step('0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Randomised traffic.
    rpe = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N_PB; b++) rp[b] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) rpe = !rpe;
      rrn = ($urandom_range(0, 399) != 0);
      step(rp, rpe, rrn, 1'b0);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
